instr_fetch_queue: RTL and testbench

Front-end fetch block that produces the 32-bit instruction stream consumed by the `ControlUnit` decoder. It issues sequential word fetches to instruction memory and buffers returned words with their PC in a small prefetch FIFO. It presents them to decode over a valid/ready handshake. A redirect from the branch/jump path flushes all buffered and in-flight instructions.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/instr_fetch_queue.sv | 124 ++++++++++++
 tb/tb_instr_fetch_queue.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch front end
package fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;

    // Canonical RISC-V NOP (addi x0, x0, 0); the core inserts it as a bubble.
    localparam logic [FETCH_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous DEPTH-entry FIFO with flush and combinational head
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_data (ignored when full unless popping in the same cycle)
//   i_pop       : advance head (ignored when empty)
//   i_flush     : drop every entry; wins over push and pop
//   o_head      : current head entry, meaningful only when o_count != 0
//   o_count     : number of stored entries, 0..DEPTH
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output T                       o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned PW = $clog2(DEPTH);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != (PW+1)'(DEPTH)) || w_do_pop);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {{PW{1'b0}}, w_do_push} - {{PW{1'b0}}, w_do_pop};
        end
    end

    // Storage needs no reset: the count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - sequential instruction prefetcher with redirect flush
//
// Ports:
//   clk, rst_n                          : clock, asynchronous active-low reset
//   imem_req/imem_addr/imem_gnt         : fetch request channel, accepted on req && gnt
//   imem_rvalid/imem_rdata              : in-order fetch responses
//   Instr/InstrPC/InstrValid/InstrReady : decode handshake, Instr/InstrPC are 0 when idle
//   Redirect/RedirectPC                 : flush everything and restart at RedirectPC
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = FETCH_XLEN,
    parameter int unsigned           ADDR_WIDTH = FETCH_XLEN,
    parameter int unsigned           DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    output logic [DATA_WIDTH-1:0] Instr,
    output logic [ADDR_WIDTH-1:0] InstrPC,
    output logic                  InstrValid,
    input  logic                  InstrReady,
    input  logic                  Redirect,
    input  logic [ADDR_WIDTH-1:0] RedirectPC
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [CW-1:0]         r_drop;
    logic [CW-1:0]         w_data_count;
    logic [CW-1:0]         w_pcq_count;
    logic [CW-1:0]         w_outstanding;
    logic [CW:0]           w_credit_used;
    logic [ADDR_WIDTH-1:0] w_pcq_head;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;
    logic                  w_accept;
    logic                  w_rsp;
    logic                  w_keep_rsp;
    logic                  w_pop;
    logic [1:0]            w_unused_redirect_lsbs;

    assign w_unused_redirect_lsbs = RedirectPC[1:0];

    // Every in-flight request is either still tracked in pc_q (live) or
    // counted in r_drop (stale), so the in-flight total is their sum.
    assign w_outstanding = w_pcq_count + r_drop;
    assign w_credit_used = {1'b0, w_data_count} + {1'b0, w_outstanding};

    // Reserving a FIFO slot for every in-flight request means a response
    // can always be accepted. rst_n gates req so it reads 0 during reset.
    assign imem_req  = rst_n && !Redirect && (w_credit_used < (CW+1)'(DEPTH));
    assign imem_addr = r_fetch_pc;
    assign w_accept  = imem_req && imem_gnt;

    // A response with nothing in flight is spurious and ignored.
    assign w_rsp      = imem_rvalid && (w_outstanding != '0);
    assign w_keep_rsp = w_rsp && (r_drop == '0) && !Redirect;

    assign InstrValid = (w_data_count != '0);
    assign w_pop      = InstrValid && InstrReady && !Redirect;

    assign w_push_entry = '{pc: w_pcq_head, instr: imem_rdata};
    assign Instr        = InstrValid ? w_head.instr : '0;
    assign InstrPC      = InstrValid ? w_head.pc : '0;

    fetch_fifo #(
        .T     (logic [ADDR_WIDTH-1:0]),
        .DEPTH (DEPTH)
    ) u_pc_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_accept),
        .i_data  (r_fetch_pc),
        .i_pop   (w_keep_rsp),
        .i_flush (Redirect),
        .o_head  (w_pcq_head),
        .o_count (w_pcq_count)
    );

    fetch_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_data_q (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_keep_rsp),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .i_flush (Redirect),
        .o_head  (w_head),
        .o_count (w_data_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_drop     <= '0;
        end else if (Redirect) begin
            // pc_q is flushed, so everything still in flight after this
            // cycle's response becomes stale.
            r_fetch_pc <= {RedirectPC[ADDR_WIDTH-1:2], 2'b00};
            r_drop     <= w_outstanding - CW'(w_rsp);
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
            end
            if (w_rsp && (r_drop != '0)) begin
                r_drop <= r_drop - 1'b1;
            end
        end
    end

    a_no_spurious_rvalid: assert property (
        @(posedge clk) disable iff (!rst_n) !(imem_rvalid && (w_outstanding == '0))
    );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] Instr;
    logic [31:0] InstrPC;
    logic        InstrValid;
    logic        InstrReady = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = '0;

    instr_fetch_queue #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .InstrPC     (InstrPC),
        .InstrValid  (InstrValid),
        .InstrReady  (InstrReady),
        .Redirect    (Redirect),
        .RedirectPC  (RedirectPC)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } req_t;

    req_t        memq[$];
    logic [31:0] m_buf[$];
    logic [31:0] m_fetch_pc;
    int          epoch;
    int          cyc;
    int          last_due;
    int          ready_pct, gnt_pct, delay_min, delay_max, redir_pm;
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] con_pc[$];
    logic [31:0] con_instr[$];
    int          con_cyc[$];
    int          first_valid_cyc;
    int          vectors = 0;
    int          miscompares = 0;

    task automatic configure(input int r, input int g, input int dmin, input int dmax, input int rd);
        ready_pct = r;
        gnt_pct   = g;
        delay_min = dmin;
        delay_max = dmax;
        redir_pm  = rd;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        Redirect    = 1'b0;
        RedirectPC  = '0;
        InstrReady  = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        memq.delete();
        m_buf.delete();
        acc_addr.delete();
        acc_cyc.delete();
        con_pc.delete();
        con_instr.delete();
        con_cyc.delete();
        m_fetch_pc      = RESET_PC;
        epoch           = 0;
        last_due        = -1;
        first_valid_cyc = -1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    // One clock cycle: drive inputs at the negedge, check outputs against the
    // model, advance the model to match the coming posedge.
    task automatic run_cycle(input bit force_redir, input logic [31:0] force_pc);
        bit   redir, rsp, exp_req, accepted, consumed;
        req_t e;
        int   d;
        InstrReady  = ($urandom_range(99) < ready_pct);
        imem_gnt    = ($urandom_range(99) < gnt_pct);
        redir       = force_redir || ($urandom_range(999) < redir_pm);
        Redirect    = redir;
        RedirectPC  = force_redir ? force_pc : $urandom;
        rsp         = (memq.size() > 0) && (memq[0].due <= cyc);
        imem_rvalid = rsp;
        imem_rdata  = rsp ? (memq[0].addr >> 2) : $urandom;
        #1;
        exp_req = !redir && ((m_buf.size() + memq.size()) < DEPTH);
        vectors++;
        if (imem_req !== exp_req) begin
            miscompares++;
            $display("FAIL imem_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req);
        end
        if (exp_req) begin
            vectors++;
            if (imem_addr !== m_fetch_pc) begin
                miscompares++;
                $display("FAIL imem_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, m_fetch_pc);
            end
        end
        vectors++;
        if (InstrValid !== (m_buf.size() > 0)) begin
            miscompares++;
            $display("FAIL InstrValid cyc=%0d got=%b exp=%b", cyc, InstrValid, m_buf.size() > 0);
        end
        vectors++;
        if (m_buf.size() > 0) begin
            if (InstrPC !== m_buf[0] || Instr !== (m_buf[0] >> 2)) begin
                miscompares++;
                $display("FAIL head cyc=%0d got pc=%h instr=%h exp pc=%h instr=%h",
                         cyc, InstrPC, Instr, m_buf[0], m_buf[0] >> 2);
            end
        end else if (Instr !== 32'h0 || InstrPC !== 32'h0) begin
            miscompares++;
            $display("FAIL idle_out cyc=%0d got pc=%h instr=%h exp 0/0", cyc, InstrPC, Instr);
        end
        if (InstrValid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
        accepted = exp_req && imem_gnt;
        consumed = (m_buf.size() > 0) && InstrReady && !redir;
        if (accepted) begin
            acc_addr.push_back(imem_addr);
            acc_cyc.push_back(cyc);
        end
        if (consumed) begin
            con_pc.push_back(InstrPC);
            con_instr.push_back(Instr);
            con_cyc.push_back(cyc);
            void'(m_buf.pop_front());
        end
        if (rsp) begin
            e = memq.pop_front();
            if (!redir && e.epoch == epoch) m_buf.push_back(e.addr);
        end
        if (accepted) begin
            d        = $urandom_range(delay_max, delay_min);
            e.addr   = m_fetch_pc;
            e.epoch  = epoch;
            e.due    = (cyc + d > last_due) ? cyc + d : last_due + 1;
            last_due = e.due;
            memq.push_back(e);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        if (redir) begin
            m_buf.delete();
            m_fetch_pc = {RedirectPC[31:2], 2'b00};
            epoch++;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        vectors += 5;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req got=%b exp=0", imem_req); end
        if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL rst_addr got=%h exp=%h", imem_addr, RESET_PC); end
        if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got=%b exp=0", InstrValid); end
        if (Instr !== 32'h0) begin miscompares++; $display("FAIL rst_instr got=%h exp=0", Instr); end
        if (InstrPC !== 32'h0) begin miscompares++; $display("FAIL rst_pc got=%h exp=0", InstrPC); end
    endtask

    task automatic test_stream();
        configure(100, 100, 1, 1, 0);
        do_reset();
        repeat (12) run_cycle(1'b0, '0);
        vectors++;
        if (first_valid_cyc != 2) begin
            miscompares++;
            $display("FAIL stream_latency got=%0d exp=2", first_valid_cyc);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= con_pc.size() || con_pc[i] !== 32'(4 * i) || con_instr[i] !== 32'(i) || con_cyc[i] != 2 + i) begin
                miscompares++;
                $display("FAIL stream_item%0d got n=%0d exp pc=%h instr=%h cyc=%0d", i, con_pc.size(), 4 * i, i, 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        configure(0, 100, 1, 1, 0);
        do_reset();
        repeat (10) run_cycle(1'b0, '0);
        vectors += 2;
        if (acc_addr.size() != DEPTH) begin
            miscompares++;
            $display("FAIL bp_requests got=%0d exp=%0d", acc_addr.size(), DEPTH);
        end
        if (imem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_req_low got=%b exp=0", imem_req);
        end
        ready_pct = 100;
        repeat (8) run_cycle(1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= con_pc.size() || con_pc[i] !== 32'(4 * i)) begin
                miscompares++;
                $display("FAIL bp_pop%0d got n=%0d exp pc=%h", i, con_pc.size(), 4 * i);
            end
        end
        vectors++;
        if (acc_addr.size() < 5 || acc_addr[4] !== 32'd16) begin
            miscompares++;
            $display("FAIL bp_resume got n=%0d exp addr=10", acc_addr.size());
        end
    endtask

    task automatic test_redirect_drop();
        configure(100, 100, 3, 3, 0);
        do_reset();
        repeat (2) run_cycle(1'b0, '0);
        vectors++;
        if (acc_addr.size() != 2) begin
            miscompares++;
            $display("FAIL rd_inflight got=%0d exp=2", acc_addr.size());
        end
        run_cycle(1'b1, 32'h0000_0103);
        repeat (12) run_cycle(1'b0, '0);
        vectors += 2;
        if (con_pc.size() == 0 || con_pc[0] !== 32'h100 || con_instr[0] !== 32'h40) begin
            miscompares++;
            $display("FAIL rd_first got n=%0d exp pc=100 instr=40", con_pc.size());
        end
        if (acc_addr.size() < 3 || acc_addr[2] !== 32'h100 || acc_cyc[2] != 3) begin
            miscompares++;
            $display("FAIL rd_refetch got n=%0d exp addr=100 cyc=3", acc_addr.size());
        end
    endtask

    task automatic test_redirect_collision();
        configure(100, 100, 1, 1, 0);
        do_reset();
        repeat (4) run_cycle(1'b0, '0);
        vectors++;
        if (InstrValid !== 1'b1) begin
            miscompares++;
            $display("FAIL col_pre_valid got=%b exp=1", InstrValid);
        end
        run_cycle(1'b1, 32'h0000_0200);
        vectors++;
        if (InstrValid !== 1'b0) begin
            miscompares++;
            $display("FAIL col_flushed got=%b exp=0", InstrValid);
        end
        repeat (8) run_cycle(1'b0, '0);
        vectors++;
        if (con_pc.size() < 3 || con_pc[2] !== 32'h200) begin
            miscompares++;
            $display("FAIL col_next got n=%0d exp pc=200", con_pc.size());
        end
    endtask

    task automatic test_wrap();
        configure(100, 100, 1, 1, 0);
        do_reset();
        run_cycle(1'b1, 32'hFFFF_FFFC);
        repeat (6) run_cycle(1'b0, '0);
        vectors += 2;
        if (acc_addr.size() < 2 || acc_addr[0] !== 32'hFFFF_FFFC || acc_addr[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_req got n=%0d exp fffffffc,0", acc_addr.size());
        end
        if (con_pc.size() < 2 || con_pc[0] !== 32'hFFFF_FFFC || con_pc[1] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_pop got n=%0d exp fffffffc,0", con_pc.size());
        end
    endtask

    task automatic test_async_reset();
        configure(0, 100, 3, 3, 0);
        do_reset();
        repeat (5) run_cycle(1'b0, '0);
        vectors++;
        if (InstrValid !== 1'b1) begin
            miscompares++;
            $display("FAIL ar_pre_valid got=%b exp=1", InstrValid);
        end
        #2;
        rst_n       = 1'b0;
        imem_rvalid = 1'b0;
        #1;
        vectors += 4;
        if (InstrValid !== 1'b0) begin miscompares++; $display("FAIL ar_valid got=%b exp=0", InstrValid); end
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL ar_req got=%b exp=0", imem_req); end
        if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL ar_addr got=%h exp=%h", imem_addr, RESET_PC); end
        if (Instr !== 32'h0 || InstrPC !== 32'h0) begin
            miscompares++;
            $display("FAIL ar_out got pc=%h instr=%h exp 0/0", InstrPC, Instr);
        end
        @(negedge clk);
        configure(100, 100, 1, 1, 0);
        do_reset();
        repeat (4) run_cycle(1'b0, '0);
        vectors++;
        if (acc_addr.size() == 0 || acc_addr[0] !== RESET_PC || acc_cyc[0] != 0) begin
            miscompares++;
            $display("FAIL ar_restart got n=%0d exp addr=%h cyc=0", acc_addr.size(), RESET_PC);
        end
    endtask

    task automatic test_random();
        configure(70, 60, 1, 4, 30);
        do_reset();
        repeat (3000) run_cycle(1'b0, '0);
        vectors++;
        if (con_pc.size() < 100) begin
            miscompares++;
            $display("FAIL rand_progress got=%0d exp>=100", con_pc.size());
        end
    endtask

    initial begin
        configure(0, 0, 1, 1, 0);
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_collision();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
